// File: rtl/riscv_muldiv_wb_queue.sv
// Writeback formatter for the pipelined mul/div unit: pairs in-order responses
// with issue-time tags, selects the 32-bit result and buffers it for writeback.
module riscv_muldiv_wb_queue #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  tag_fn,
    input  logic [4:0]  tag_waddr,
    input  logic        tag_val,
    output logic        tag_rdy,
    input  logic [63:0] muldivresp_msg_result,
    input  logic        muldivresp_val,
    output logic        muldivresp_rdy,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_waddr,
    output logic        wb_val,
    input  logic        wb_rdy,
    output logic        busy,
    output logic        err_orphan
);

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] TAG_FULL = CW'(TAG_DEPTH);

    // Tag FIFO state
    logic [2:0]    fn_q   [TAG_DEPTH];
    logic [4:0]    dst_q  [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] tag_count_q, tag_count_d;

    // Output buffer: entry 0 is always the head
    logic [31:0]   ent0_data_q, ent0_data_d;
    logic [4:0]    ent0_waddr_q, ent0_waddr_d;
    logic [31:0]   ent1_data_q, ent1_data_d;
    logic [4:0]    ent1_waddr_q, ent1_waddr_d;
    logic [1:0]    out_count_q, out_count_d;
    logic          err_orphan_q, err_orphan_d;

    logic          push;
    logic          accept;
    logic          orphan;
    logic          pop;
    logic          enq;
    logic          deq;
    logic [2:0]    head_fn;
    logic [4:0]    head_dst;
    logic [31:0]   sel_data;

    // Ready signals depend only on registered counts
    assign tag_rdy        = (tag_count_q != TAG_FULL);
    assign muldivresp_rdy = (out_count_q != 2'd2) || (tag_count_q == '0);

    assign push   = tag_val && tag_rdy;
    assign accept = muldivresp_val && muldivresp_rdy;
    assign orphan = accept && (tag_count_q == '0);
    assign pop    = accept && (tag_count_q != '0);
    assign enq    = pop;
    assign deq    = wb_val && wb_rdy;

    assign head_fn  = fn_q[rd_ptr_q];
    assign head_dst = dst_q[rd_ptr_q];

    always_comb begin
        sel_data = muldivresp_msg_result[31:0];
        case (head_fn)
            FN_MUL, FN_DIV, FN_DIVU: sel_data = muldivresp_msg_result[31:0];
            FN_REM, FN_REMU:         sel_data = muldivresp_msg_result[63:32];
            default:                 sel_data = muldivresp_msg_result[31:0];
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tag_count_d  = tag_count_q;
        err_orphan_d = err_orphan_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        tag_count_d = tag_count_q + CW'(push) - CW'(pop);
        if (orphan) begin
            err_orphan_d = 1'b1;
        end
    end

    always_comb begin
        ent0_data_d  = ent0_data_q;
        ent0_waddr_d = ent0_waddr_q;
        ent1_data_d  = ent1_data_q;
        ent1_waddr_d = ent1_waddr_q;
        if (deq && (out_count_q == 2'd2)) begin
            ent0_data_d  = ent1_data_q;
            ent0_waddr_d = ent1_waddr_q;
        end
        // Enqueue with two entries held cannot happen: rdy is low then
        if (enq) begin
            if ((out_count_q == 2'd0) || ((out_count_q == 2'd1) && deq)) begin
                ent0_data_d  = sel_data;
                ent0_waddr_d = head_dst;
            end else begin
                ent1_data_d  = sel_data;
                ent1_waddr_d = head_dst;
            end
        end
        out_count_d = out_count_q + 2'(enq) - 2'(deq);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fn_q[wr_ptr_q]  <= tag_fn;
            dst_q[wr_ptr_q] <= tag_waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_count_q  <= '0;
            ent0_data_q  <= '0;
            ent0_waddr_q <= '0;
            ent1_data_q  <= '0;
            ent1_waddr_q <= '0;
            out_count_q  <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_count_q  <= tag_count_d;
            ent0_data_q  <= ent0_data_d;
            ent0_waddr_q <= ent0_waddr_d;
            ent1_data_q  <= ent1_data_d;
            ent1_waddr_q <= ent1_waddr_d;
            out_count_q  <= out_count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign wb_data    = ent0_data_q;
    assign wb_waddr   = ent0_waddr_q;
    assign wb_val     = (out_count_q != 2'd0);
    assign busy       = (tag_count_q != '0) || (out_count_q != 2'd0);
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_riscv_muldiv_wb_queue.sv
// Directed bench for riscv_muldiv_wb_queue: ordering, select, backpressure,
// tag FIFO full/wrap, orphan handling and mid-operation reset.
module tb_riscv_muldiv_wb_queue;

    localparam logic [2:0] F_MUL  = 3'd0;
    localparam logic [2:0] F_DIV  = 3'd1;
    localparam logic [2:0] F_DIVU = 3'd2;
    localparam logic [2:0] F_REM  = 3'd3;
    localparam logic [2:0] F_REMU = 3'd4;

    logic        clk;
    logic        reset;
    logic [2:0]  tag_fn;
    logic [4:0]  tag_waddr;
    logic        tag_val;
    logic        tag_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val;
    logic        muldivresp_rdy;
    logic [31:0] wb_data;
    logic [4:0]  wb_waddr;
    logic        wb_val;
    logic        wb_rdy;
    logic        busy;
    logic        err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    riscv_muldiv_wb_queue #(.TAG_DEPTH(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .tag_fn                (tag_fn),
        .tag_waddr             (tag_waddr),
        .tag_val               (tag_val),
        .tag_rdy               (tag_rdy),
        .muldivresp_msg_result (muldivresp_msg_result),
        .muldivresp_val        (muldivresp_val),
        .muldivresp_rdy        (muldivresp_rdy),
        .wb_data               (wb_data),
        .wb_waddr              (wb_waddr),
        .wb_val                (wb_val),
        .wb_rdy                (wb_rdy),
        .busy                  (busy),
        .err_orphan            (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc(); cyc(); cyc();
        n_cmp++; if (tag_rdy !== 1'b1) begin n_err++; $display("FAIL reset_tag_rdy got=%b exp=1", tag_rdy); end
        n_cmp++; if (muldivresp_rdy !== 1'b1) begin n_err++; $display("FAIL reset_resp_rdy got=%b exp=1", muldivresp_rdy); end
        n_cmp++; if (wb_val !== 1'b0) begin n_err++; $display("FAIL reset_wb_val got=%b exp=0", wb_val); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
        n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        n_cmp++; if (wb_waddr !== 5'd0) begin n_err++; $display("FAIL reset_wb_waddr got=%0d exp=0", wb_waddr); end
    endtask

    task automatic test_mul();
        tag_fn = F_MUL; tag_waddr = 5'd5; tag_val = 1'b1;
        cyc();
        tag_val = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_tag got=%b exp=1", busy); end
        cyc(); cyc();
        wb_rdy = 1'b1;
        muldivresp_msg_result = 64'h00000001_FFFFFFFE;
        muldivresp_val = 1'b1;
        n_cmp++; if (muldivresp_rdy !== 1'b1) begin n_err++; $display("FAIL mul_resp_rdy got=%b exp=1", muldivresp_rdy); end
        cyc();
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_val !== 1'b1) begin n_err++; $display("FAIL mul_wb_val got=%b exp=1", wb_val); end
        n_cmp++; if (wb_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mul_wb_data got=%h exp=fffffffe", wb_data); end
        n_cmp++; if (wb_waddr !== 5'd5) begin n_err++; $display("FAIL mul_wb_waddr got=%0d exp=5", wb_waddr); end
        cyc();
        n_cmp++; if (wb_val !== 1'b0) begin n_err++; $display("FAIL mul_drained_val got=%b exp=0", wb_val); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mul_busy_done got=%b exp=0", busy); end
        n_cmp++; if (wb_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mul_data_hold got=%h exp=fffffffe", wb_data); end
    endtask

    task automatic test_rem_divu();
        tag_fn = F_REM; tag_waddr = 5'd3; tag_val = 1'b1;
        cyc();
        tag_fn = F_DIVU; tag_waddr = 5'd4;
        cyc();
        tag_val = 1'b0;
        wb_rdy = 1'b1;
        muldivresp_msg_result = {32'h00000007, 32'h00000002};
        muldivresp_val = 1'b1;
        cyc();
        muldivresp_msg_result = {32'h00000001, 32'h0000000A};
        n_cmp++; if (wb_val !== 1'b1) begin n_err++; $display("FAIL rem_wb_val got=%b exp=1", wb_val); end
        n_cmp++; if (wb_data !== 32'h00000007) begin n_err++; $display("FAIL rem_wb_data got=%h exp=00000007", wb_data); end
        n_cmp++; if (wb_waddr !== 5'd3) begin n_err++; $display("FAIL rem_wb_waddr got=%0d exp=3", wb_waddr); end
        cyc();
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_data !== 32'h0000000A) begin n_err++; $display("FAIL divu_wb_data got=%h exp=0000000a", wb_data); end
        n_cmp++; if (wb_waddr !== 5'd4) begin n_err++; $display("FAIL divu_wb_waddr got=%0d exp=4", wb_waddr); end
        cyc();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL remdivu_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_wrap();
        int q[$];
        int exp_w;
        wb_rdy = 1'b1;
        tag_fn = F_MUL;
        tag_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tag_waddr = 5'(10 + i);
            cyc();
            q.push_back(10 + i);
        end
        // Full: this push must be refused even though a pop happens this cycle
        tag_waddr = 5'd14;
        muldivresp_msg_result = {32'h0, 32'd100};
        muldivresp_val = 1'b1;
        n_cmp++; if (tag_rdy !== 1'b0) begin n_err++; $display("FAIL full_tag_rdy got=%b exp=0", tag_rdy); end
        cyc();
        exp_w = q.pop_front();
        n_cmp++; if (tag_rdy !== 1'b1) begin n_err++; $display("FAIL full_pop_tag_rdy got=%b exp=1", tag_rdy); end
        n_cmp++; if (wb_data !== 32'd100 || wb_waddr !== 5'(exp_w)) begin n_err++; $display("FAIL full_pop_out got=%0d/r%0d exp=100/r%0d", wb_data, wb_waddr, exp_w); end
        for (int i = 0; i < 8; i++) begin
            tag_waddr = 5'(20 + i);
            tag_fn = (i % 2 == 0) ? F_DIV : F_MUL;
            muldivresp_msg_result = {32'hDEAD0000, 32'(200 + i)};
            cyc();
            q.push_back(20 + i);
            exp_w = q.pop_front();
            n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'(200 + i) || wb_waddr !== 5'(exp_w)) begin n_err++; $display("FAIL wrap_pair%0d got=%b/%0d/r%0d exp=1/%0d/r%0d", i, wb_val, wb_data, wb_waddr, 200 + i, exp_w); end
        end
        tag_val = 1'b0;
        for (int j = 0; j < 3; j++) begin
            muldivresp_msg_result = {32'h0, 32'(300 + j)};
            cyc();
            exp_w = q.pop_front();
            n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'(300 + j) || wb_waddr !== 5'(exp_w)) begin n_err++; $display("FAIL wrap_drain%0d got=%b/%0d/r%0d exp=1/%0d/r%0d", j, wb_val, wb_data, wb_waddr, 300 + j, exp_w); end
        end
        muldivresp_val = 1'b0;
        cyc();
        n_cmp++; if (wb_val !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL wrap_idle got=%b/%b exp=0/0", wb_val, busy); end
    endtask

    task automatic test_backpressure();
        wb_rdy = 1'b0;
        tag_val = 1'b1;
        tag_fn = F_REMU; tag_waddr = 5'd7; cyc();
        tag_fn = F_DIV;  tag_waddr = 5'd8; cyc();
        tag_fn = F_MUL;  tag_waddr = 5'd9; cyc();
        tag_val = 1'b0;
        muldivresp_val = 1'b1;
        muldivresp_msg_result = {32'd9, 32'd1};
        cyc();
        muldivresp_msg_result = {32'd0, 32'd22};
        cyc();
        muldivresp_msg_result = {32'd0, 32'd33};
        n_cmp++; if (muldivresp_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_full got=%b exp=0", muldivresp_rdy); end
        n_cmp++; if (wb_data !== 32'd9 || wb_waddr !== 5'd7) begin n_err++; $display("FAIL bp_head got=%0d/r%0d exp=9/r7", wb_data, wb_waddr); end
        cyc();
        n_cmp++; if (muldivresp_rdy !== 1'b0 || wb_data !== 32'd9) begin n_err++; $display("FAIL bp_stall got=%b/%0d exp=0/9", muldivresp_rdy, wb_data); end
        wb_rdy = 1'b1;
        n_cmp++; if (muldivresp_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_indep_wb got=%b exp=0", muldivresp_rdy); end
        cyc();
        n_cmp++; if (wb_data !== 32'd22 || wb_waddr !== 5'd8 || muldivresp_rdy !== 1'b1) begin n_err++; $display("FAIL bp_second got=%0d/r%0d/%b exp=22/r8/1", wb_data, wb_waddr, muldivresp_rdy); end
        cyc();
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'd33 || wb_waddr !== 5'd9) begin n_err++; $display("FAIL bp_third got=%b/%0d/r%0d exp=1/33/r9", wb_val, wb_data, wb_waddr); end
        cyc();
        n_cmp++; if (wb_val !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_idle got=%b/%b exp=0/0", wb_val, busy); end
    endtask

    task automatic test_orphan();
        wb_rdy = 1'b1;
        tag_fn = F_MUL; tag_waddr = 5'd12; tag_val = 1'b1;
        muldivresp_msg_result = {32'h0, 32'd55};
        muldivresp_val = 1'b1;
        n_cmp++; if (muldivresp_rdy !== 1'b1) begin n_err++; $display("FAIL orphan_rdy got=%b exp=1", muldivresp_rdy); end
        cyc();
        tag_val = 1'b0;
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_val !== 1'b0 || err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_drop got=%b/%b exp=0/1", wb_val, err_orphan); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL orphan_tag_kept got=%b exp=1", busy); end
        muldivresp_msg_result = {32'h0, 32'd66};
        muldivresp_val = 1'b1;
        cyc();
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'd66 || wb_waddr !== 5'd12) begin n_err++; $display("FAIL orphan_next got=%b/%0d/r%0d exp=1/66/r12", wb_val, wb_data, wb_waddr); end
        cyc(); cyc();
        n_cmp++; if (err_orphan !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL orphan_sticky got=%b/%b exp=1/0", err_orphan, busy); end
    endtask

    task automatic test_reset_mid();
        wb_rdy = 1'b0;
        tag_fn = F_DIV; tag_val = 1'b1;
        tag_waddr = 5'd1; cyc();
        tag_waddr = 5'd2; cyc();
        tag_waddr = 5'd3; cyc();
        tag_val = 1'b0;
        muldivresp_msg_result = {32'h0, 32'h1234};
        muldivresp_val = 1'b1;
        cyc();
        muldivresp_val = 1'b0;
        n_cmp++; if (wb_val !== 1'b1 || wb_data !== 32'h1234 || busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%b/%h/%b exp=1/1234/1", wb_val, wb_data, busy); end
        reset = 1'b1;
        tag_val = 1'b1; tag_waddr = 5'd6;
        muldivresp_val = 1'b1;
        wb_rdy = 1'b1;
        cyc();
        reset = 1'b0;
        tag_val = 1'b0;
        muldivresp_val = 1'b0;
        n_cmp++; if (tag_rdy !== 1'b1 || muldivresp_rdy !== 1'b1) begin n_err++; $display("FAIL rstmid_rdy got=%b/%b exp=1/1", tag_rdy, muldivresp_rdy); end
        n_cmp++; if (wb_val !== 1'b0 || busy !== 1'b0 || err_orphan !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got=%b/%b/%b exp=0/0/0", wb_val, busy, err_orphan); end
        n_cmp++; if (wb_data !== 32'h0 || wb_waddr !== 5'd0) begin n_err++; $display("FAIL rstmid_out got=%h/r%0d exp=0/r0", wb_data, wb_waddr); end
        cyc();
        n_cmp++; if (busy !== 1'b0 || wb_val !== 1'b0) begin n_err++; $display("FAIL rstmid_idle got=%b/%b exp=0/0", busy, wb_val); end
    endtask

    initial begin
        reset = 1'b1;
        tag_fn = 3'd0;
        tag_waddr = 5'd0;
        tag_val = 1'b0;
        muldivresp_msg_result = 64'h0;
        muldivresp_val = 1'b0;
        wb_rdy = 1'b0;
        test_reset();
        test_mul();
        test_rem_divu();
        test_full_wrap();
        test_backpressure();
        test_orphan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
